// File: rtl/write_buffer_if.sv
// Processor/memory bus bundle: request fields flow master->slave, completion flows back.
interface write_buffer_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        write;
  logic        size;
  logic [1:0]  prot;
  logic [1:0]  trans;
  logic [31:0] rdata;
  logic        data_valid;
  logic        abort;

  modport master (
    output addr, wdata, write, size, prot, trans,
    input  rdata, data_valid, abort
  );

  modport slave (
    input  addr, wdata, write, size, prot, trans,
    output rdata, data_valid, abort
  );
endinterface

// File: rtl/write_buffer.sv
// Posted-write buffer: bufferable writes complete in one cycle and drain in order.
// Optional read forwarding from the buffer is enabled with `define WB_FORWARD_EN.
//
// state   | meaning
// M_IDLE  | no downstream transfer; FIFO head has priority over a pending pass-through
// M_DRAIN | FIFO head driven downstream, waiting for mem data_valid
// M_PASS  | read or non-bufferable write driven downstream, waiting for mem data_valid
module write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           n_reset,
  write_buffer_if.slave  cpu,
  write_buffer_if.master mem,
  input  logic           err_clr,
  output logic           wb_empty,
  output logic           wb_error
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {M_IDLE, M_DRAIN, M_PASS} m_state_t;
  m_state_t state_q, state_d;

  logic [31:0]      fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic             fifo_size [DEPTH];
  logic [1:0]       fifo_prot [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  logic [31:0] pend_addr, pend_wdata;
  logic        pend_write, pend_size, pend_valid;
  logic [1:0]  pend_prot, pend_trans;

  logic        cpu_req, is_buf, push, pop, accept_pass, accept_fwd;
  logic        load_drain, load_pass, pass_done;
  logic [31:0] fwd_data;

  // A request is only sampled when no completion is on the bus and nothing is pending.
  assign cpu_req     = (cpu.trans != 2'b00) && !cpu.data_valid && !pend_valid;
  assign is_buf      = cpu.write && cpu.prot[1];
  assign push        = cpu_req && is_buf && (count < CNT_FULL);
  assign accept_pass = cpu_req && !is_buf && !accept_fwd;

`ifdef WB_FORWARD_EN
  logic fwd_hit;

  // Scan oldest to youngest so the youngest matching word entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count) && fifo_size[rd_ptr + PTR_W'(i)] &&
          (fifo_addr[rd_ptr + PTR_W'(i)] == cpu.addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data[rd_ptr + PTR_W'(i)];
      end
    end
  end

  assign accept_fwd = cpu_req && !cpu.write && cpu.size && fwd_hit;
`else
  assign accept_fwd = 1'b0;
  assign fwd_data   = '0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= M_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_drain = 1'b0;
    load_pass  = 1'b0;
    pop        = 1'b0;
    pass_done  = 1'b0;
    case (state_q)
      M_IDLE: begin
        if (count != '0) begin
          load_drain = 1'b1;
          state_d    = M_DRAIN;
        end else if (pend_valid || accept_pass) begin
          load_pass = 1'b1;
          state_d   = M_PASS;
        end
      end
      M_DRAIN: begin
        if (mem.data_valid) begin
          pop     = 1'b1;
          state_d = M_IDLE;
        end
      end
      M_PASS: begin
        if (mem.data_valid) begin
          pass_done = 1'b1;
          state_d   = M_IDLE;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu.addr;
      fifo_data[wr_ptr] <= cpu.wdata;
      fifo_size[wr_ptr] <= cpu.size;
      fifo_prot[wr_ptr] <= cpu.prot;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      pend_write <= 1'b0;
      pend_size  <= 1'b0;
      pend_prot  <= '0;
      pend_trans <= '0;
    end else if (accept_pass) begin
      pend_valid <= 1'b1;
      pend_addr  <= cpu.addr;
      pend_wdata <= cpu.wdata;
      pend_write <= cpu.write;
      pend_size  <= cpu.size;
      pend_prot  <= cpu.prot;
      pend_trans <= cpu.trans;
    end else if (pass_done) begin
      pend_valid <= 1'b0;
    end
  end

  // A pass-through accepted while the path is free issues straight from the cpu bus.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mem.addr  <= '0;
      mem.wdata <= '0;
      mem.write <= 1'b0;
      mem.size  <= 1'b0;
      mem.prot  <= '0;
      mem.trans <= '0;
    end else if (load_drain) begin
      mem.addr  <= fifo_addr[rd_ptr];
      mem.wdata <= fifo_data[rd_ptr];
      mem.write <= 1'b1;
      mem.size  <= fifo_size[rd_ptr];
      mem.prot  <= fifo_prot[rd_ptr];
      mem.trans <= 2'b10;
    end else if (load_pass) begin
      mem.addr  <= pend_valid ? pend_addr  : cpu.addr;
      mem.wdata <= pend_valid ? pend_wdata : cpu.wdata;
      mem.write <= pend_valid ? pend_write : cpu.write;
      mem.size  <= pend_valid ? pend_size  : cpu.size;
      mem.prot  <= pend_valid ? pend_prot  : cpu.prot;
      mem.trans <= pend_valid ? pend_trans : cpu.trans;
    end else if (pop || pass_done) begin
      mem.trans <= 2'b00;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cpu.data_valid <= 1'b0;
      cpu.abort      <= 1'b0;
      cpu.rdata      <= '0;
    end else begin
      cpu.data_valid <= push || accept_fwd || pass_done;
      cpu.abort      <= pass_done && mem.abort;
      if (pass_done)       cpu.rdata <= mem.rdata;
      else if (accept_fwd) cpu.rdata <= fwd_data;
    end
  end

  // Set has priority over clear so an abort landing with err_clr is not lost.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) wb_error <= 1'b0;
    else          wb_error <= (pop && mem.abort) || (wb_error && !err_clr);
  end

  assign wb_empty = (count == '0) && (state_q == M_IDLE) && !pend_valid;

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: cpu responses and downstream transfers are queued
// as expectations when driven and compared when they appear on the bus.
module tb_write_buffer;
  logic clk, n_reset, err_clr, wb_empty, wb_error;

  write_buffer_if cpu_bus();
  write_buffer_if mem_bus();

  write_buffer #(.DEPTH(4)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .cpu      (cpu_bus),
    .mem      (mem_bus),
    .err_clr  (err_clr),
    .wb_empty (wb_empty),
    .wb_error (wb_error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        size;
    logic [1:0]  prot;
  } mem_tx_t;

  typedef struct {
    logic [31:0] rdata;
    logic        abort;
    bit          chk_rd;
  } cpu_rsp_t;

  mem_tx_t  exp_mem[$];
  cpu_rsp_t exp_cpu[$];
  mem_tx_t  tx_h;
  cpu_rsp_t rsp_h;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int first_dv_cyc = -1;
  int last_dv_cyc = 0;
  int valid_cyc = 0;
  int lat;
  bit mem_stall = 1'b0;
  bit resp_done = 1'b0;
  logic [31:0] abort_addr = 32'hFFFF_FFFF;
  logic [31:0] mem_rd_val = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory model: answers each downstream transfer once, unless stalled.
  always @(negedge clk) begin
    if (!n_reset) begin
      mem_bus.data_valid = 1'b0;
      mem_bus.abort      = 1'b0;
      mem_bus.rdata      = 32'h0;
      resp_done          = 1'b0;
    end else if (mem_bus.trans != 2'b00 && !resp_done && !mem_stall) begin
      chk("mem_tx_expected", 32'(exp_mem.size() != 0), 1);
      if (exp_mem.size() != 0) begin
        tx_h = exp_mem.pop_front();
        chk("mem_addr",  mem_bus.addr,  tx_h.addr);
        chk("mem_wdata", mem_bus.wdata, tx_h.wdata);
        chk("mem_write", mem_bus.write, tx_h.write);
        chk("mem_size",  mem_bus.size,  tx_h.size);
        chk("mem_prot",  mem_bus.prot,  tx_h.prot);
      end
      mem_bus.data_valid = 1'b1;
      mem_bus.abort      = (mem_bus.addr == abort_addr);
      mem_bus.rdata      = mem_rd_val;
      resp_done          = 1'b1;
      last_dv_cyc        = cyc;
      if (first_dv_cyc < 0) first_dv_cyc = cyc;
    end else begin
      mem_bus.data_valid = 1'b0;
      mem_bus.abort      = 1'b0;
      if (mem_bus.trans == 2'b00) resp_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (n_reset && cpu_bus.data_valid === 1'b1) begin
      chk("cpu_rsp_expected", 32'(exp_cpu.size() != 0), 1);
      if (exp_cpu.size() != 0) begin
        rsp_h = exp_cpu.pop_front();
        chk("cpu_abort", cpu_bus.abort, rsp_h.abort);
        if (rsp_h.chk_rd) chk("cpu_rdata", cpu_bus.rdata, rsp_h.rdata);
      end
    end
  end

  // Drives one request (from a negedge) and holds it through the completion cycle.
  task automatic cpu_xfer(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                          input logic sz, input logic [1:0] pr, input logic [31:0] exp_rd,
                          input logic exp_ab, input bit chk_rd, input bit to_mem,
                          input bit chk_issue, output int l);
    cpu_rsp_t r;
    mem_tx_t  t;
    r.rdata = exp_rd; r.abort = exp_ab; r.chk_rd = chk_rd;
    exp_cpu.push_back(r);
    if (to_mem) begin
      t.addr = a; t.wdata = wd; t.write = wr; t.size = sz; t.prot = pr;
      exp_mem.push_back(t);
    end
    cpu_bus.addr  = a;
    cpu_bus.wdata = wd;
    cpu_bus.write = wr;
    cpu_bus.size  = sz;
    cpu_bus.prot  = pr;
    cpu_bus.trans = 2'b10;
    l = 0;
    do begin
      @(negedge clk);
      l++;
      if (chk_issue && l == 1) chk("pass_issue_n1", 32'(mem_bus.trans != 2'b00), 1);
    end while (cpu_bus.data_valid !== 1'b1 && l < 300);
    if (cpu_bus.data_valid !== 1'b1) chk("cpu_timeout", cpu_bus.data_valid, 1);
    valid_cyc = cyc;
    cpu_bus.trans = 2'b00;
  endtask

  task automatic wr_buf(input logic [31:0] a, input logic [31:0] d, output int l);
    cpu_xfer(a, d, 1'b1, 1'b1, 2'b10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, l);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (wb_empty !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, wb_empty, 1);
  endtask

  initial begin
    n_reset = 1'b0;
    err_clr = 1'b0;
    cpu_bus.addr = '0; cpu_bus.wdata = '0; cpu_bus.write = 1'b0;
    cpu_bus.size = 1'b0; cpu_bus.prot = '0; cpu_bus.trans = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cpu_dv",    cpu_bus.data_valid, 0);
    chk("rst_cpu_abort", cpu_bus.abort, 0);
    chk("rst_cpu_rdata", cpu_bus.rdata, 0);
    chk("rst_mem_trans", mem_bus.trans, 0);
    chk("rst_mem_addr",  mem_bus.addr, 0);
    chk("rst_wb_empty",  wb_empty, 1);
    chk("rst_wb_error",  wb_error, 0);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_mem_trans", mem_bus.trans, 0);

    // Single buffered write, then a byte write with prot pass-through
    wr_buf(32'h100, 32'hDEADBEEF, lat);
    chk("buf_lat", lat, 1);
    wait_empty("t2_empty");
    @(negedge clk);
    cpu_xfer(32'h104, 32'h0000_0055, 1'b1, 1'b0, 2'b11, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, lat);
    chk("buf_byte_lat", lat, 1);
    wait_empty("t2b_empty");

    // Full FIFO: fifth write stalls until the first pop, then is accepted a cycle later
    mem_stall = 1'b1;
    for (int i = 1; i <= 4; i++) wr_buf(32'h1000 + 32'(i) * 4, 32'hC0DE_0000 + 32'(i), lat);
    first_dv_cyc = -1;
    fork
      wr_buf(32'h1014, 32'hC0DE_0005, lat);
      begin
        repeat (6) @(negedge clk);
        chk("full_stall_dv", cpu_bus.data_valid, 0);
        mem_stall = 1'b0;
      end
    join
    chk("full_accept_after_pop", valid_cyc - first_dv_cyc, 2);
    wait_empty("t3_empty");

    // Read waits for queued writes, then returns memory data one cycle after completion
    mem_stall = 1'b1;
    mem_rd_val = 32'h12345678;
    wr_buf(32'h210, 32'h1111_0001, lat);
    wr_buf(32'h220, 32'h1111_0002, lat);
    fork
      cpu_xfer(32'h200, 32'h0, 1'b0, 1'b1, 2'b11, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b0, lat);
      begin
        repeat (4) @(negedge clk);
        chk("read_held_dv", cpu_bus.data_valid, 0);
        mem_stall = 1'b0;
      end
    join
    chk("pass_rsp_lat", valid_cyc - last_dv_cyc, 1);
    wait_empty("t4_empty");

    // Aborts: buffered write is sticky in wb_error, pass-through aborts reach the cpu
    @(negedge clk);
    abort_addr = 32'h300;
    wr_buf(32'h300, 32'hBAD0_0300, lat);
    wait_empty("t5_empty");
    chk("err_set", wb_error, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", wb_error, 0);
    err_clr = 1'b1;
    wr_buf(32'h300, 32'hBAD0_0301, lat);
    wait_empty("t5b_empty");
    chk("err_set_wins", wb_error, 1);
    @(negedge clk);
    chk("err_clr_after", wb_error, 0);
    err_clr = 1'b0;
    @(negedge clk);
    cpu_xfer(32'h300, 32'h0BAD_0BAD, 1'b1, 1'b1, 2'b01, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, lat);
    chk("pass_rsp_lat2", valid_cyc - last_dv_cyc, 1);
    chk("pass_abort_no_err", wb_error, 0);
    abort_addr = 32'hFFFF_FFFF;
    wait_empty("t5c_empty");

    // Reset in the middle of a drain discards queued writes
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) wr_buf(32'h600 + 32'(i) * 4, 32'h6600_0000 + 32'(i), lat);
    repeat (3) @(negedge clk);
    chk("drain_active", 32'(mem_bus.trans != 2'b00), 1);
    n_reset = 1'b0;
    exp_mem.delete();
    exp_cpu.delete();
    @(negedge clk);
    chk("rst_drain_empty", wb_empty, 1);
    chk("rst_drain_trans", mem_bus.trans, 0);
    n_reset = 1'b1;
    mem_stall = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_empty", wb_empty, 1);
    chk("post_rst_trans", mem_bus.trans, 0);
    wr_buf(32'h700, 32'h7777_7777, lat);
    wait_empty("t6_empty");

`ifdef WB_FORWARD_EN
    // Word read hitting the buffer is answered from the youngest matching entry
    mem_stall = 1'b1;
    wr_buf(32'h400, 32'h0BAD_F00D, lat);
    wr_buf(32'h404, 32'h1357_9BDF, lat);
    wr_buf(32'h400, 32'hA5A5_A5A5, lat);
    @(negedge clk);
    cpu_xfer(32'h400, 32'h0, 1'b0, 1'b1, 2'b10, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0, 1'b0, lat);
    chk("fwd_lat", lat, 1);
    mem_rd_val = 32'h0000_00C3;
    fork
      cpu_xfer(32'h400, 32'h0, 1'b0, 1'b0, 2'b10, 32'h0000_00C3, 1'b0, 1'b1, 1'b1, 1'b0, lat);
      begin
        repeat (3) @(negedge clk);
        mem_stall = 1'b0;
      end
    join
    wait_empty("fwd_empty");
`endif

    repeat (5) @(negedge clk);
    chk("mem_all_issued", exp_mem.size(), 0);
    chk("cpu_all_answered", exp_cpu.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
